// File: rtl/conv_post_mac.sv
// conv_post_mac: per-pixel multiply / cross-channel accumulate / requantise,
// with an output FIFO drained onto the bus BUS_LANES bytes per beat.
// Optional build macro CONV_POST_RELU_EN fuses a ReLU after saturation.
module conv_post_mac #(
  parameter int unsigned IN_CH      = 4,
  parameter int unsigned OUT_CH     = 16,
  parameter int unsigned DW         = 8,
  parameter int unsigned WW         = 8,
  parameter int unsigned ACCW       = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BUS_LANES  = 4,
  parameter int unsigned PIXW       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [PIXW-1:0]               pix_total,
  input  logic [4:0]                    shift_i,
  input  logic [IN_CH*DW-1:0]           data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [IN_CH*OUT_CH*WW-1:0]    weight_i,
  input  logic                          bus_free,
  output logic [BUS_LANES*DW-1:0]       data_o,
  output logic                          valid_o,
  output logic                          conv_done,
  output logic                          busy
);

  localparam int unsigned PW     = DW + WW;
  localparam int unsigned SW     = ACCW + 1;
  localparam int unsigned VW     = OUT_CH * DW;
  localparam int unsigned NBEATS = OUT_CH / BUS_LANES;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DW - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - SW'(1);

`ifdef CONV_POST_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [PIXW-1:0]        total_q, acc_cnt, acc_cnt_nxt;
  logic [4:0]             shift_q;
  logic                   fire, wr, beat_fire, last_beat, pop;
  logic                   s1_v, s2_v, s3_v;
  logic signed [PW-1:0]   prod_q [IN_CH][OUT_CH];
  logic signed [ACCW-1:0] acc_c [OUT_CH];
  logic signed [ACCW-1:0] acc_q [OUT_CH];
  logic signed [SW-1:0]   rnd_c;
  logic signed [SW-1:0]   sum_c [OUT_CH];
  logic signed [SW-1:0]   r_c [OUT_CH];
  logic [DW-1:0]          q_c [OUT_CH];
  logic [VW-1:0]          rq_c, s3_q;
  logic [VW-1:0]          mem [FIFO_DEPTH];
  logic [VW-1:0]          head_c;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_nxt;
  logic [CW:0]            occ_nxt;
  logic [BW-1:0]          beat_idx;
  logic [BUS_LANES*DW-1:0] beat_c;

  // Handshake, FIFO occupancy and next-state bookkeeping
  always_comb begin
    fire        = valid_i & ready_o;
    wr          = s3_v;
    beat_fire   = bus_free & (count != '0);
    last_beat   = (beat_idx == BW'(NBEATS - 1));
    pop         = beat_fire & last_beat;
    count_nxt   = count + CW'(wr) - CW'(pop);
    acc_cnt_nxt = acc_cnt + PIXW'(fire);
    // Occupancy the FIFO will be committed to next cycle, including stages in flight
    occ_nxt     = (CW+1)'(count_nxt) + (CW+1)'(fire) + (CW+1)'(s1_v) + (CW+1)'(s2_v);
    state_nxt   = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (acc_cnt_nxt == total_q) state_nxt = DRAIN;
      DRAIN: if (!s1_v && !s2_v && !s3_v && count == '0) state_nxt = DONE;
      DONE:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Pass control FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      total_q   <= '0;
      shift_q   <= '0;
      acc_cnt   <= '0;
      ready_o   <= 1'b0;
      busy      <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      ready_o   <= (state_nxt == RUN) && (occ_nxt < (CW+1)'(FIFO_DEPTH));
      busy      <= (state_nxt == RUN) || (state_nxt == DRAIN);
      conv_done <= (state_nxt == DONE);
      if (start && (state == IDLE || state == DONE)) begin
        total_q <= (pix_total == '0) ? PIXW'(1) : pix_total;
        shift_q <= shift_i;
        acc_cnt <= '0;
      end else begin
        acc_cnt <= acc_cnt_nxt;
      end
    end
  end

  // Stage valid shift register; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
    end else begin
      s1_v <= fire;
      s2_v <= s1_v;
      s3_v <= s2_v;
    end
  end

  // Cross-channel sum of the registered products
  always_comb begin
    for (int o = 0; o < OUT_CH; o++) begin
      acc_c[o] = '0;
      for (int c = 0; c < IN_CH; c++) begin
        acc_c[o] = acc_c[o] + ACCW'(prod_q[c][o]);
      end
    end
  end

  // Round-half-up arithmetic shift, saturation and optional ReLU
  always_comb begin
    rnd_c = (shift_q == 5'd0) ? '0 : $signed(SW'(1) << (shift_q - 5'd1));
    rq_c  = '0;
    for (int o = 0; o < OUT_CH; o++) begin
      sum_c[o] = SW'(acc_q[o]) + rnd_c;
      r_c[o]   = sum_c[o] >>> shift_q;
      if (r_c[o] > SAT_MAX) begin
        q_c[o] = SAT_MAX[DW-1:0];
      end else if (r_c[o] < SAT_MIN) begin
        q_c[o] = SAT_MIN[DW-1:0];
      end else begin
        q_c[o] = r_c[o][DW-1:0];
      end
      if (RELU && q_c[o][DW-1]) q_c[o] = '0;
      rq_c[o*DW +: DW] = q_c[o];
    end
  end

  // Datapath stage registers, qualified by the stage valids
  always_ff @(posedge clk) begin
    if (fire) begin
      for (int c = 0; c < IN_CH; c++) begin
        for (int o = 0; o < OUT_CH; o++) begin
          prod_q[c][o] <= PW'($signed(data_i[c*DW +: DW])) *
                          PW'($signed(weight_i[(c*OUT_CH+o)*WW +: WW]));
        end
      end
    end
    if (s1_v) acc_q <= acc_c;
    if (s2_v) s3_q  <= rq_c;
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= s3_q;
  end

  // Select the current beat: lowest channel of the beat lands in the top byte
  always_comb begin
    head_c = mem[rd_ptr];
    beat_c = '0;
    for (int l = 0; l < BUS_LANES; l++) begin
      beat_c[(BUS_LANES-1-l)*DW +: DW] = head_c[(int'(beat_idx)*BUS_LANES + l)*DW +: DW];
    end
  end

  // FIFO pointers, beat sequencing and registered bus output
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat_idx <= '0;
      valid_o  <= 1'b0;
      data_o   <= '0;
    end else begin
      count   <= count_nxt;
      valid_o <= beat_fire;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (beat_fire) begin
        data_o   <= beat_c;
        beat_idx <= last_beat ? '0 : beat_idx + BW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

endmodule
